body_integrator: RTL and testbench



---
 rtl/body_integrator.sv | 199 +++++++++++++++++++
 tb/tb_body_integrator.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/body_integrator.sv
// Semi-implicit Euler integration stage: per body reads vel/acc then pos from the register
// file, updates v and p in Q16.16, writes both back. BODY_INTEGRATOR_SAT_EN selects saturating adds.
module body_integrator #(
  parameter int unsigned NUM_BODIES = 10,
  parameter int unsigned DT_SHIFT   = 6,
  parameter int unsigned POS_X_BASE = 24,
  parameter int unsigned POS_Y_BASE = 34,
  parameter int unsigned POS_Z_BASE = 44,
  parameter int unsigned VEL_X_BASE = 54,
  parameter int unsigned VEL_Y_BASE = 64,
  parameter int unsigned VEL_Z_BASE = 74,
  parameter int unsigned ACC_X_BASE = 84,
  parameter int unsigned ACC_Y_BASE = 94,
  parameter int unsigned ACC_Z_BASE = 104
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        START,
  input  logic [31:0] PLANET_NUM,
  output logic        BUSY,
  output logic        DONE,
  output logic [1:0]  RE,
  output logic [1:0]  WE,
  output logic [31:0] ADDR1,
  output logic [31:0] ADDR2,
  output logic [31:0] ADDR3,
  output logic [31:0] ADDR4,
  output logic [31:0] ADDR5,
  output logic [31:0] ADDR6,
  output logic [31:0] DATA1,
  output logic [31:0] DATA2,
  output logic [31:0] DATA3,
  output logic [31:0] DATA4,
  output logic [31:0] DATA5,
  output logic [31:0] DATA6,
  input  logic [31:0] DATA1in,
  input  logic [31:0] DATA2in,
  input  logic [31:0] DATA3in,
  input  logic [31:0] DATA4in,
  input  logic [31:0] DATA5in,
  input  logic [31:0] DATA6in
);

  localparam int unsigned KW = $clog2(NUM_BODIES + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD_VA  = 3'd1;
  localparam logic [2:0] S_CAP_VA = 3'd2;
  localparam logic [2:0] S_RD_P   = 3'd3;
  localparam logic [2:0] S_CAP_P  = 3'd4;
  localparam logic [2:0] S_WR     = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  logic [2:0]       state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [KW-1:0]    n_q, n_d;
  logic [2:0][31:0] v_q, v_d;
  logic [2:0][31:0] p_q, p_d;

  logic [2:0][31:0] vel_in, acc_in, pos_in;
  logic [31:0]      k_ext;

  assign vel_in = {DATA3in, DATA2in, DATA1in};
  assign acc_in = {DATA6in, DATA5in, DATA4in};
  assign pos_in = {DATA3in, DATA2in, DATA1in};
  assign k_ext  = 32'(k_q);

  function automatic logic [31:0] asr(input logic [31:0] x);
    return 32'($signed(x) >>> DT_SHIFT);
  endfunction

  function automatic logic [31:0] add_q(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] s;
    s = a + b;
`ifdef BODY_INTEGRATOR_SAT_EN
    // Overflow only when both operands share a sign that the sum loses
    if (a[31] == b[31] && s[31] != a[31]) begin
      s = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
`endif
    return s;
  endfunction

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    n_d     = n_q;
    v_d     = v_q;
    p_d     = p_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          k_d = '0;
          n_d = (PLANET_NUM > 32'(NUM_BODIES)) ? KW'(NUM_BODIES) : KW'(PLANET_NUM);
          state_d = (n_d == '0) ? S_DONE : S_RD_VA;
        end
      end
      S_RD_VA: state_d = S_CAP_VA;
      S_CAP_VA: begin
        for (int i = 0; i < 3; i++) begin
          v_d[i] = add_q(vel_in[i], asr(acc_in[i]));
        end
        state_d = S_RD_P;
      end
      S_RD_P: state_d = S_CAP_P;
      S_CAP_P: begin
        for (int i = 0; i < 3; i++) begin
          p_d[i] = add_q(pos_in[i], asr(v_q[i]));
        end
        state_d = S_WR;
      end
      S_WR: begin
        if (k_q == n_q - KW'(1)) begin
          state_d = S_DONE;
        end else begin
          k_d     = k_q + KW'(1);
          state_d = S_RD_VA;
        end
      end
      S_DONE: begin
        if (!START) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      n_q     <= '0;
      v_q     <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      n_q     <= n_d;
      v_q     <= v_d;
      p_q     <= p_d;
    end
  end

  // Outputs decode from state only, so an asynchronous reset clears them immediately
  always_comb begin
    BUSY  = (state_q != S_IDLE) && (state_q != S_DONE);
    DONE  = (state_q == S_DONE);
    RE    = 2'd0;
    WE    = 2'd0;
    ADDR1 = '0;
    ADDR2 = '0;
    ADDR3 = '0;
    ADDR4 = '0;
    ADDR5 = '0;
    ADDR6 = '0;
    DATA1 = '0;
    DATA2 = '0;
    DATA3 = '0;
    DATA4 = '0;
    DATA5 = '0;
    DATA6 = '0;
    case (state_q)
      S_RD_VA: begin
        RE    = 2'd3;
        ADDR1 = VEL_X_BASE + k_ext;
        ADDR2 = VEL_Y_BASE + k_ext;
        ADDR3 = VEL_Z_BASE + k_ext;
        ADDR4 = ACC_X_BASE + k_ext;
        ADDR5 = ACC_Y_BASE + k_ext;
        ADDR6 = ACC_Z_BASE + k_ext;
      end
      S_RD_P: begin
        RE    = 2'd3;
        ADDR1 = POS_X_BASE + k_ext;
        ADDR2 = POS_Y_BASE + k_ext;
        ADDR3 = POS_Z_BASE + k_ext;
        ADDR4 = POS_X_BASE + k_ext;
        ADDR5 = POS_Y_BASE + k_ext;
        ADDR6 = POS_Z_BASE + k_ext;
      end
      S_WR: begin
        WE    = 2'd3;
        ADDR1 = VEL_X_BASE + k_ext;
        ADDR2 = VEL_Y_BASE + k_ext;
        ADDR3 = VEL_Z_BASE + k_ext;
        ADDR4 = POS_X_BASE + k_ext;
        ADDR5 = POS_Y_BASE + k_ext;
        ADDR6 = POS_Z_BASE + k_ext;
        DATA1 = v_q[0];
        DATA2 = v_q[1];
        DATA3 = v_q[2];
        DATA4 = p_q[0];
        DATA5 = p_q[1];
        DATA6 = p_q[2];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_body_integrator.sv
// Self-checking bench for body_integrator: behavioural register file, write-back scoreboard
// and per-scenario tasks.
module tb_body_integrator;

  localparam int POS_X = 24, POS_Y = 34, POS_Z = 44;
  localparam int VEL_X = 54, VEL_Y = 64, VEL_Z = 74;
  localparam int ACC_X = 84, ACC_Y = 94, ACC_Z = 104;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        START;
  logic [31:0] PLANET_NUM;
  logic        BUSY, DONE;
  logic [1:0]  RE, WE;
  logic [31:0] ADDR1, ADDR2, ADDR3, ADDR4, ADDR5, ADDR6;
  logic [31:0] DATA1, DATA2, DATA3, DATA4, DATA5, DATA6;
  logic [31:0] DATA1in, DATA2in, DATA3in, DATA4in, DATA5in, DATA6in;

  body_integrator dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .PLANET_NUM(PLANET_NUM),
    .BUSY(BUSY), .DONE(DONE), .RE(RE), .WE(WE),
    .ADDR1(ADDR1), .ADDR2(ADDR2), .ADDR3(ADDR3), .ADDR4(ADDR4), .ADDR5(ADDR5), .ADDR6(ADDR6),
    .DATA1(DATA1), .DATA2(DATA2), .DATA3(DATA3), .DATA4(DATA4), .DATA5(DATA5), .DATA6(DATA6),
    .DATA1in(DATA1in), .DATA2in(DATA2in), .DATA3in(DATA3in),
    .DATA4in(DATA4in), .DATA5in(DATA5in), .DATA6in(DATA6in)
  );

  always #10 CLK = ~CLK;

  logic [31:0] mem [0:127];

  // Register file model: reads registered on RE, writes on WE
  always @(posedge CLK) begin
    if (RE == 2'd3) begin
      DATA1in <= mem[ADDR1[6:0]];
      DATA2in <= mem[ADDR2[6:0]];
      DATA3in <= mem[ADDR3[6:0]];
      DATA4in <= mem[ADDR4[6:0]];
      DATA5in <= mem[ADDR5[6:0]];
      DATA6in <= mem[ADDR6[6:0]];
    end
    if (WE == 2'd3) begin
      mem[ADDR1[6:0]] <= DATA1;
      mem[ADDR2[6:0]] <= DATA2;
      mem[ADDR3[6:0]] <= DATA3;
      mem[ADDR4[6:0]] <= DATA4;
      mem[ADDR5[6:0]] <= DATA5;
      mem[ADDR6[6:0]] <= DATA6;
    end
  end

  typedef struct packed {
    logic [5:0][31:0] addr;
    logic [5:0][31:0] data;
  } txn_t;

  txn_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] m_shr(input logic [31:0] x);
    longint sx = longint'($signed(x));
    longint q  = sx / 64;
    if (sx < 0 && (sx % 64) != 0) q = q - 1;
    return q[31:0];
  endfunction

  function automatic logic [31:0] m_add(input logic [31:0] a, input logic [31:0] b);
    longint s = longint'($signed(a)) + longint'($signed(b));
`ifdef BODY_INTEGRATOR_SAT_EN
    if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
`endif
    return s[31:0];
  endfunction

  function automatic txn_t model_body(input int k);
    txn_t t;
    int vb[3] = '{VEL_X, VEL_Y, VEL_Z};
    int pb[3] = '{POS_X, POS_Y, POS_Z};
    int ab[3] = '{ACC_X, ACC_Y, ACC_Z};
    for (int i = 0; i < 3; i++) begin
      t.addr[i]     = 32'(vb[i] + k);
      t.addr[i + 3] = 32'(pb[i] + k);
      t.data[i]     = m_add(mem[vb[i] + k], m_shr(mem[ab[i] + k]));
      t.data[i + 3] = m_add(mem[pb[i] + k], m_shr(t.data[i]));
    end
    return t;
  endfunction

  always @(negedge CLK) begin
    if (WE == 2'd3) begin
      txn_t e;
      logic [5:0][31:0] oa, od;
      oa = {ADDR6, ADDR5, ADDR4, ADDR3, ADDR2, ADDR1};
      od = {DATA6, DATA5, DATA4, DATA3, DATA2, DATA1};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: got write addr1=%0d data1=%h, required none", ADDR1, DATA1);
      end else begin
        e = sb.pop_front();
        if (oa !== e.addr || od !== e.data)
          begin
            errors++;
            $display("FAIL wr_txn: got addr=%h data=%h, required addr=%h data=%h",
                     oa, od, e.addr, e.data);
          end
      end
    end
  end

  task automatic clear_mem();
    @(negedge CLK);
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
  endtask

  task automatic fill_random(input int nb);
    @(negedge CLK);
    for (int k = 0; k < nb; k++) begin
      mem[VEL_X + k] = $urandom; mem[VEL_Y + k] = $urandom; mem[VEL_Z + k] = $urandom;
      mem[POS_X + k] = $urandom; mem[POS_Y + k] = $urandom; mem[POS_Z + k] = $urandom;
      mem[ACC_X + k] = $urandom; mem[ACC_Y + k] = $urandom; mem[ACC_Z + k] = $urandom;
    end
  endtask

  // Raise START, return cycles from the sampling edge until DONE (-1 on timeout)
  task automatic go(input logic [31:0] pn, output int cyc);
    @(negedge CLK);
    PLANET_NUM = pn;
    START = 1'b1;
    cyc = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge CLK);
      #1;
      if (DONE) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic end_run();
    @(negedge CLK);
    START = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if ({BUSY, DONE, RE, WE} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got busy/done/re/we=%b, required 000000", {BUSY, DONE, RE, WE});
    end
    checks++;
    if ({ADDR1, ADDR6, DATA1, DATA6} !== 128'h0) begin
      errors++;
      $display("FAIL reset_bus: got addr1=%h addr6=%h data1=%h data6=%h, required 0",
               ADDR1, ADDR6, DATA1, DATA6);
    end
  endtask

  task automatic test_single();
    int cyc;
    clear_mem();
    mem[ACC_X] = 32'h0001_0000;
    sb.push_back(model_body(0));
    go(32'd1, cyc);
    checks++;
    if (cyc !== 6) begin
      errors++;
      $display("FAIL single_latency: got %0d cycles, required 6", cyc);
    end
    end_run();
    checks++;
    if (mem[VEL_X] !== 32'h0000_0400 || mem[POS_X] !== 32'h0000_0010) begin
      errors++;
      $display("FAIL single_values: got vx=%h px=%h, required 00000400 00000010",
               mem[VEL_X], mem[POS_X]);
    end
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL single_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_zero();
    int cyc = -1;
    int bus = 0;
    @(negedge CLK);
    PLANET_NUM = 32'd0;
    START = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge CLK);
      #1;
      if (RE != 2'd0 || WE != 2'd0) bus++;
      if (DONE && cyc < 0) cyc = i;
    end
    checks++;
    if (cyc !== 1) begin
      errors++;
      $display("FAIL zero_latency: got %0d cycles, required 1", cyc);
    end
    checks++;
    if (bus !== 0) begin
      errors++;
      $display("FAIL zero_bus: got %0d active cycles, required 0", bus);
    end
    end_run();
    checks++;
    if (DONE !== 1'b0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL zero_idle: got done=%b busy=%b, required 0 0", DONE, BUSY);
    end
  endtask

  task automatic test_clamp();
    int cyc;
    fill_random(10);
    for (int k = 0; k < 10; k++) sb.push_back(model_body(k));
    go(32'd12, cyc);
    checks++;
    if (cyc !== 51) begin
      errors++;
      $display("FAIL clamp_latency: got %0d cycles, required 51", cyc);
    end
    end_run();
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL clamp_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_neg_shift();
    int cyc;
    clear_mem();
    mem[ACC_Y] = 32'hFFFF_FFFF;
    mem[POS_Y] = 32'h1234_5678;
    sb.push_back(model_body(0));
    go(32'd1, cyc);
    end_run();
    checks++;
    if (mem[VEL_Y] !== 32'hFFFF_FFFF || mem[POS_Y] !== 32'h1234_5677) begin
      errors++;
      $display("FAIL neg_shift: got vy=%h py=%h, required ffffffff 12345677",
               mem[VEL_Y], mem[POS_Y]);
    end
  endtask

  task automatic test_overflow();
    int cyc;
    logic [31:0] exp_v;
`ifdef BODY_INTEGRATOR_SAT_EN
    exp_v = 32'h7FFF_FFFF;
`else
    exp_v = 32'h8000_03F0;
`endif
    clear_mem();
    mem[VEL_X] = 32'h7FFF_FFF0;
    mem[ACC_X] = 32'h0001_0000;
    sb.push_back(model_body(0));
    go(32'd1, cyc);
    end_run();
    checks++;
    if (mem[VEL_X] !== exp_v) begin
      errors++;
      $display("FAIL overflow_vx: got %h, required %h", mem[VEL_X], exp_v);
    end
  endtask

  task automatic test_reset_midrun();
    txn_t e0, e1;
    logic [31:0] keep [2][9];
    int bad = 0;
    fill_random(4);
    e0 = model_body(0);
    e1 = model_body(1);
    sb.push_back(e0);
    sb.push_back(e1);
    for (int k = 2; k < 4; k++) begin
      keep[k-2] = '{mem[VEL_X+k], mem[VEL_Y+k], mem[VEL_Z+k], mem[POS_X+k], mem[POS_Y+k],
                    mem[POS_Z+k], mem[ACC_X+k], mem[ACC_Y+k], mem[ACC_Z+k]};
    end
    @(negedge CLK);
    PLANET_NUM = 32'd4;
    START = 1'b1;
    repeat (14) @(posedge CLK);
    #1;
    checks++;
    if (BUSY !== 1'b1) begin
      errors++;
      $display("FAIL midrun_busy: got busy=%b, required 1", BUSY);
    end
    RESET_N = 1'b0;
    START = 1'b0;
    #1;
    checks++;
    if ({BUSY, DONE, RE, WE, ADDR1, DATA4} !== 70'h0) begin
      errors++;
      $display("FAIL midrun_async: got busy=%b done=%b re=%0d we=%0d addr1=%h, required zeros",
               BUSY, DONE, RE, WE, ADDR1);
    end
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL midrun_writes: got %0d pending, required 0", sb.size());
    end
    for (int k = 2; k < 4; k++) begin
      logic [31:0] now [9];
      now = '{mem[VEL_X+k], mem[VEL_Y+k], mem[VEL_Z+k], mem[POS_X+k], mem[POS_Y+k],
              mem[POS_Z+k], mem[ACC_X+k], mem[ACC_Y+k], mem[ACC_Z+k]};
      for (int i = 0; i < 9; i++) if (now[i] !== keep[k-2][i]) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL midrun_untouched: got %0d altered words, required 0", bad);
    end
    checks++;
    if (mem[VEL_X+1] !== e1.data[0] || mem[POS_Z+1] !== e1.data[5]
        || mem[VEL_Y] !== e0.data[1]) begin
      errors++;
      $display("FAIL midrun_updated: got vx1=%h pz1=%h vy0=%h, required %h %h %h",
               mem[VEL_X+1], mem[POS_Z+1], mem[VEL_Y], e1.data[0], e1.data[5], e0.data[1]);
    end
  endtask

  task automatic test_start_hold();
    int cyc;
    int bad = 0;
    clear_mem();
    mem[ACC_X] = 32'h0002_0000;
    sb.push_back(model_body(0));
    go(32'd1, cyc);
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK);
      #1;
      if (!DONE || BUSY) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL hold_done: got %0d cycles not in DONE, required 0", bad);
    end
    end_run();
    checks++;
    if (DONE !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: got done=%b, required 0", DONE);
    end
    sb.push_back(model_body(0));
    go(32'd1, cyc);
    checks++;
    if (cyc !== 6) begin
      errors++;
      $display("FAIL hold_rerun_latency: got %0d cycles, required 6", cyc);
    end
    end_run();
    checks++;
    if (mem[VEL_X] !== 32'h0000_1000 || mem[POS_X] !== 32'h0000_0060) begin
      errors++;
      $display("FAIL hold_rerun_values: got vx=%h px=%h, required 00001000 00000060",
               mem[VEL_X], mem[POS_X]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1);
  end

  initial begin
    RESET_N    = 1'b0;
    START      = 1'b0;
    PLANET_NUM = 32'd0;
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    repeat (3) @(posedge CLK);
    #1;
    test_reset();
    @(negedge CLK);
    RESET_N = 1'b1;
    test_single();
    test_zero();
    test_clamp();
    test_neg_shift();
    test_overflow();
    test_reset_midrun();
    test_start_hold();
    repeat (3) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
